// File: rtl/fadd_share_arb_if.sv
// Handshake bundle shared by the FPU clients, the adder arbiter and the
// result consumer. Requester i owns bits [32i+31:32i] of req_x1/req_x2.
interface fadd_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_x1;
  logic [32*NREQ-1:0] req_x2;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_y;
  logic               rsp_ovf;
  logic [IDW-1:0]     rsp_id;

  // Client and result-consumer side
  modport master (output req_valid, req_x1, req_x2, rsp_ready,
                  input  req_ready, rsp_valid, rsp_y, rsp_ovf, rsp_id);

  // Arbiter side
  modport slave  (input  req_valid, req_x1, req_x2, rsp_ready,
                  output req_ready, rsp_valid, rsp_y, rsp_ovf, rsp_id);
endinterface

// File: rtl/fadd_share_arb.sv
// One combinational single-precision adder (fadd) time-shared among NREQ
// requesters. A round-robin arbiter picks one request, the operands are
// registered, the sum is registered one cycle later and held until the
// consumer takes it. Sequence per operation: IDLE (accept) -> CALC -> RESP.

// Combinational binary32 adder. Magnitudes are aligned on the larger
// exponent, the result is truncated toward zero, zero exponents are treated
// as zero, and an exponent reaching 255 yields a signed infinity with ovf.
// Infinity/NaN inputs pass the larger-magnitude operand through unchanged.
module fadd (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);
  // Leading-zero count of a 24-bit significand (24 when the value is zero)
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end else begin
        n     = n;
      end
    end
    return n;
  endfunction

  logic [31:0] big_s;
  logic [31:0] small_s;
  logic [7:0]  eb_s;
  logic [7:0]  es_s;
  logic [7:0]  ediff_s;
  logic [23:0] mb_s;
  logic [23:0] ms_s;
  logic [23:0] ms_al_s;
  logic [24:0] sum_s;
  logic [23:0] diff_s;
  logic [4:0]  lz_s;
  logic [22:0] norm_s;
  logic [8:0]  exp_s;
  logic [22:0] mant_s;

  // Align, add or subtract magnitudes, normalise, and flag exponent overflow
  always_comb begin
    y   = 32'd0;
    ovf = 1'b0;
    if (x1[30:0] >= x2[30:0]) begin
      big_s   = x1;
      small_s = x2;
    end else begin
      big_s   = x2;
      small_s = x1;
    end
    eb_s    = big_s[30:23];
    es_s    = small_s[30:23];
    mb_s    = (eb_s != 8'd0) ? {1'b1, big_s[22:0]}   : 24'd0;
    ms_s    = (es_s != 8'd0) ? {1'b1, small_s[22:0]} : 24'd0;
    ediff_s = eb_s - es_s;
    ms_al_s = (ediff_s > 8'd23) ? 24'd0 : (ms_s >> ediff_s);
    sum_s   = {1'b0, mb_s} + {1'b0, ms_al_s};
    diff_s  = mb_s - ms_al_s;
    lz_s    = lzc24(diff_s);
    norm_s  = 23'(diff_s << lz_s);
    if (sum_s[24]) begin
      exp_s  = {1'b0, eb_s} + 9'd1;
      mant_s = sum_s[23:1];
    end else begin
      exp_s  = {1'b0, eb_s};
      mant_s = sum_s[22:0];
    end

    if (eb_s == 8'hFF) begin
      y = big_s;
    end else if (big_s[31] == small_s[31]) begin
      if (exp_s >= 9'd255) begin
        y   = {big_s[31], 8'hFF, 23'd0};
        ovf = 1'b1;
      end else begin
        y   = {big_s[31], exp_s[7:0], mant_s};
      end
    end else begin
      if (diff_s == 24'd0) begin
        y = 32'd0;
      end else if ({3'b000, lz_s} >= eb_s) begin
        y = {big_s[31], 31'd0};
      end else begin
        y = {big_s[31], eb_s - {3'b000, lz_s}, norm_s};
      end
    end
  end
endmodule

module fadd_share_arb #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rstn,
  fadd_share_arb_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]    op_x1_q, op_x1_d;
  logic [31:0]    op_x2_q, op_x2_d;
  logic [31:0]    rsp_y_q, rsp_y_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic           hi_found_s;
  logic [IDW-1:0] hi_idx_s;
  logic           lo_found_s;
  logic [IDW-1:0] lo_idx_s;
  logic           grant_found_s;
  logic [IDW-1:0] grant_idx_s;
  logic [NREQ-1:0] grant_onehot_s;
  logic [31:0]    grant_x1_s;
  logic [31:0]    grant_x2_s;
  logic [NREQ-1:0] req_ready_s;
  logic [31:0]    fadd_y_s;
  logic           fadd_ovf_s;

  fadd u_fadd (
    .x1  (op_x1_q),
    .x2  (op_x2_q),
    .y   (fadd_y_s),
    .ovf (fadd_ovf_s)
  );

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall
  always_comb begin
    hi_found_s = 1'b0;
    hi_idx_s   = {IDW{1'b0}};
    lo_found_s = 1'b0;
    lo_idx_s   = {IDW{1'b0}};
    for (int j = NREQ - 1; j >= 0; j--) begin
      lo_found_s = lo_found_s | bus.req_valid[j];
      lo_idx_s   = bus.req_valid[j] ? IDW'(j) : lo_idx_s;
      hi_found_s = hi_found_s | (bus.req_valid[j] && (j >= int'(rr_ptr_q)));
      hi_idx_s   = (bus.req_valid[j] && (j >= int'(rr_ptr_q))) ? IDW'(j) : hi_idx_s;
    end
    grant_found_s = hi_found_s | lo_found_s;
    grant_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
  end

  // Decode the winner into a one-hot vector and select its operands
  always_comb begin
    grant_onehot_s = {NREQ{1'b0}};
    grant_x1_s     = 32'd0;
    grant_x2_s     = 32'd0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_found_s && (IDW'(j) == grant_idx_s)) begin
        grant_onehot_s[j] = 1'b1;
        grant_x1_s        = bus.req_x1[32*j +: 32];
        grant_x2_s        = bus.req_x2[32*j +: 32];
      end else begin
        grant_onehot_s[j] = 1'b0;
      end
    end
  end

  // Sequencer next state plus datapath register updates
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_x1_d     = op_x1_q;
    op_x2_d     = op_x2_q;
    rsp_y_d     = rsp_y_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_s = {NREQ{1'b0}};
    case (state_q)
      IDLE: begin
        if (grant_found_s) begin
          req_ready_s = grant_onehot_s;
          op_x1_d     = grant_x1_s;
          op_x2_d     = grant_x2_s;
          rsp_id_d    = grant_idx_s;
          rr_ptr_d    = (int'(grant_idx_s) == NREQ - 1) ? {IDW{1'b0}}
                                                         : grant_idx_s + IDW'(1);
          state_d     = CALC;
        end else begin
          state_d     = IDLE;
        end
      end
      CALC: begin
        rsp_y_d     = fadd_y_s;
        rsp_ovf_d   = fadd_ovf_s;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, pointer and datapath registers; reset discards any in-flight op
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= {IDW{1'b0}};
      op_x1_q     <= 32'd0;
      op_x2_q     <= 32'd0;
      rsp_y_q     <= 32'd0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= {IDW{1'b0}};
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_x1_q     <= op_x1_d;
      op_x2_q     <= op_x2_d;
      rsp_y_q     <= rsp_y_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Grants are suppressed while reset is held even though state already reads IDLE
  assign bus.req_ready = req_ready_s & {NREQ{rstn}};
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_fadd_share_arb.sv
// Bench for fadd_share_arb: directed scenarios plus random traffic, checked
// each cycle against a transaction-level model (round-robin pick, fixed
// two-cycle response latency, hold-until-consumed) and exact float sums.
module tb_fadd_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int VW   = NREQ + 1 + 32 + 1 + IDW;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fadd_share_arb_if #(.NREQ(NREQ)) bus ();
  fadd_share_arb #(.NREQ(NREQ)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        tb_valid [NREQ];
  logic [31:0] tb_x1    [NREQ];
  logic [31:0] tb_x2    [NREQ];
  logic [31:0] tb_ey    [NREQ];
  logic        tb_eovf  [NREQ];
  logic        tb_rsp_ready;
  bit          hold_mode;

  bit          m_pending;
  int          m_age;
  int          m_ptr;
  int          m_id;
  logic [31:0] m_y;
  logic        m_ovf;
  int          exp_grant;
  int          model_grants;

  int obs_grant_q[$];
  int obs_cyc_q[$];
  int obs_rsp_id_q[$];

  logic [VW-1:0] obs_vec;
  logic [VW-1:0] exp_vec;

  // Exact binary32 encoding of v * 2^scale (|v| < 2^24)
  function automatic logic [31:0] int_to_fp(input longint v, input int scale);
    longint m;
    int p;
    logic [31:0] r;
    if (v == 0) return 32'h0000_0000;
    m = (v < 0) ? -v : v;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    r[31]    = (v < 0);
    r[30:23] = 8'(p + scale + 127);
    r[22:0]  = 23'((m << (23 - p)) & 64'h7F_FFFF);
    return r;
  endfunction

  task automatic new_op(input int i);
    int a, b, scale;
    a = int'($urandom_range(1, 1 << 20));
    b = int'($urandom_range(1, 1 << 20));
    if ($urandom_range(0, 1) == 1) a = -a;
    if ($urandom_range(0, 1) == 1) b = -b;
    scale = int'($urandom_range(0, 40)) - 20;
    tb_x1[i]    = int_to_fp(a, scale);
    tb_x2[i]    = int_to_fp(b, scale);
    tb_ey[i]    = int_to_fp(longint'(a) + longint'(b), scale);
    tb_eovf[i]  = 1'b0;
    tb_valid[i] = 1'b1;
  endtask

  task automatic model_clear();
    m_pending = 0; m_age = 0; m_ptr = 0; m_id = 0; m_y = 32'd0; m_ovf = 1'b0;
    model_grants = 0;
    obs_grant_q.delete(); obs_cyc_q.delete(); obs_rsp_id_q.delete();
  endtask

  task automatic inputs_clear();
    for (int i = 0; i < NREQ; i++) begin
      tb_valid[i] = 1'b0; tb_x1[i] = 32'd0; tb_x2[i] = 32'd0;
      tb_ey[i] = 32'd0; tb_eovf[i] = 1'b0;
    end
    tb_rsp_ready = 1'b1;
    hold_mode    = 1'b0;
    bus.req_valid = '0; bus.req_x1 = '0; bus.req_x2 = '0; bus.rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    inputs_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
  endtask

  // Drive this cycle's inputs, then record DUT outputs and model expectations
  task automatic cycle_begin();
    logic [31:0] y_part;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]       = tb_valid[i];
      bus.req_x1[32*i +: 32] = tb_x1[i];
      bus.req_x2[32*i +: 32] = tb_x2[i];
    end
    bus.rsp_ready = tb_rsp_ready;
    #1;
    exp_grant = -1;
    if (!m_pending) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (exp_grant < 0 && tb_valid[idx]) exp_grant = idx;
      end
    end
    exp_vec = '0;
    if (exp_grant >= 0) exp_vec[VW-1-(NREQ-1-exp_grant)] = 1'b1;
    if (m_pending && m_age >= 2) begin
      y_part = m_y;
      exp_vec[VW-NREQ-1] = 1'b1;
      exp_vec[IDW+32:0]  = {y_part, m_ovf, IDW'(m_id)};
    end
    obs_vec = {bus.req_ready, bus.rsp_valid,
               {bus.rsp_y, bus.rsp_ovf, bus.rsp_id} & {(33 + IDW){bus.rsp_valid}}};
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_ready[i] === 1'b1) begin
        obs_grant_q.push_back(i);
        obs_cyc_q.push_back(cyc);
      end
    end
    if (bus.rsp_valid === 1'b1 && tb_rsp_ready) obs_rsp_id_q.push_back(int'(bus.rsp_id));
  endtask

  // Advance the model across the coming rising edge
  task automatic cycle_end();
    if (m_pending) begin
      if (m_age >= 2 && tb_rsp_ready) m_pending = 0;
      else if (m_age < 2) m_age++;
    end else if (exp_grant >= 0) begin
      m_pending = 1; m_age = 1; m_id = exp_grant;
      m_y = tb_ey[exp_grant]; m_ovf = tb_eovf[exp_grant];
      m_ptr = (exp_grant + 1) % NREQ;
      model_grants++;
      if (!hold_mode) tb_valid[exp_grant] = 1'b0;
    end
    cyc++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    inputs_clear();
    bus.req_valid = '1;
    #3;
    checks++;
    if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    checks++;
    if ({bus.rsp_valid, bus.rsp_y, bus.rsp_ovf, bus.rsp_id} !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.rsp_valid, bus.rsp_y, bus.rsp_ovf, bus.rsp_id});
    end
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    inputs_clear();
    model_clear();
    for (int c = 0; c < 2; c++) begin
      cycle_begin();
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL reset_idle c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      cycle_end();
    end
  endtask

  task automatic test_single();
    do_reset();
    tb_valid[0] = 1'b1; tb_x1[0] = 32'h3F80_0000; tb_x2[0] = 32'h3F80_0000;
    tb_ey[0] = 32'h4000_0000; tb_eovf[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle_begin();
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL single c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      if (c == 2) begin
        checks++;
        if ({bus.rsp_valid, bus.rsp_y, bus.rsp_ovf, bus.rsp_id} !== {1'b1, 32'h4000_0000, 1'b0, 2'd0}) begin
          failures++;
          $display("FAIL single_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_y, bus.rsp_ovf, bus.rsp_id},
                   {1'b1, 32'h4000_0000, 1'b0, 2'd0});
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    hold_mode = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      tb_valid[i] = 1'b1; tb_x1[i] = 32'h3FC0_0000; tb_x2[i] = 32'h4010_0000;
      tb_ey[i] = 32'h4070_0000; tb_eovf[i] = 1'b0;
    end
    for (int c = 0; c < 18; c++) begin
      cycle_begin();
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL rr c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      cycle_end();
    end
    hold_mode = 1'b0;
    checks++;
    if (obs_grant_q.size() != 6) begin
      failures++; $display("FAIL rr_count got=%0d exp=6", obs_grant_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (obs_grant_q[k] != k % NREQ) begin failures++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, obs_grant_q[k], k % NREQ); end
        if (k > 0) begin
          checks++;
          if (obs_cyc_q[k] - obs_cyc_q[k-1] != 3) begin
            failures++; $display("FAIL rr_spacing k=%0d got=%0d exp=3", k, obs_cyc_q[k] - obs_cyc_q[k-1]);
          end
        end
      end
    end
    for (int i = 0; i < NREQ; i++) tb_valid[i] = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    tb_valid[2] = 1'b1; tb_x1[2] = 32'hFF2D_94EB; tb_x2[2] = 32'hFF3B_0723;
    tb_ey[2] = 32'hFF80_0000; tb_eovf[2] = 1'b1;
    tb_rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle_begin();
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL ovf c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      if (c == 2) begin
        checks++;
        if ({bus.rsp_valid, bus.rsp_y, bus.rsp_ovf, bus.rsp_id} !== {1'b1, 32'hFF80_0000, 1'b1, 2'd2}) begin
          failures++;
          $display("FAIL ovf_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_y, bus.rsp_ovf, bus.rsp_id},
                   {1'b1, 32'hFF80_0000, 1'b1, 2'd2});
        end
      end
      cycle_end();
    end
  endtask

  // Continues from test_overflow: its response is still waiting
  task automatic test_backpressure();
    new_op(1);
    new_op(3);
    tb_rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle_begin();
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL bp_hold c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      checks++;
      if ({bus.req_ready, bus.rsp_y, bus.rsp_id} !== {4'b0000, 32'hFF80_0000, 2'd2}) begin
        failures++; $display("FAIL bp_stable c=%0d got=%h", c, {bus.req_ready, bus.rsp_y, bus.rsp_id});
      end
      cycle_end();
    end
    tb_rsp_ready = 1'b1;
    obs_grant_q.delete();
    for (int c = 0; c < 9; c++) begin
      cycle_begin();
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL bp_drain c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      cycle_end();
    end
    checks++;
    if (obs_grant_q.size() != 2 || obs_grant_q[0] != 3 || obs_grant_q[1] != 1) begin
      failures++; $display("FAIL bp_order got_n=%0d exp=3,1", obs_grant_q.size());
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    new_op(1);
    cycle_begin();
    checks++;
    if (obs_vec !== exp_vec) begin failures++; $display("FAIL midrst_grant got=%h exp=%h", obs_vec, exp_vec); end
    cycle_end();
    @(posedge clk);
    #2;
    rstn = 1'b0;
    bus.req_valid = 4'b1000;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_y} !== {4'b0000, 1'b0, 32'd0}) begin
      failures++; $display("FAIL midrst_async got=%h exp=0", {bus.req_ready, bus.rsp_valid, bus.rsp_y});
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    inputs_clear();
    model_clear();
    new_op(3);
    for (int c = 0; c < 7; c++) begin
      cycle_begin();
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL midrst_after c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      cycle_end();
    end
    checks++;
    if (obs_grant_q.size() != 1 || obs_grant_q[0] != 3 || obs_rsp_id_q.size() != 1 || obs_rsp_id_q[0] != 3) begin
      failures++;
      $display("FAIL midrst_only3 grants=%0d rsps=%0d exp=1,1", obs_grant_q.size(), obs_rsp_id_q.size());
    end
    new_op(0);
    new_op(3);
    cycle_begin();
    checks++;
    if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_ptr got=%b exp=0001", bus.req_ready); end
    cycle_end();
  endtask

  task automatic test_drop();
    do_reset();
    new_op(0);
    new_op(1);
    for (int c = 0; c < 8; c++) begin
      cycle_begin();
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL drop c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      cycle_end();
      if (c == 0) tb_valid[1] = 1'b0;
    end
    checks++;
    if (obs_grant_q.size() != 1 || obs_grant_q[0] != 0 || obs_rsp_id_q.size() != 1 || obs_rsp_id_q[0] != 0) begin
      failures++;
      $display("FAIL drop_none grants=%0d rsps=%0d exp=1,1", obs_grant_q.size(), obs_rsp_id_q.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!tb_valid[i] && $urandom_range(0, 2) == 0) new_op(i);
        else if (tb_valid[i] && $urandom_range(0, 15) == 0) tb_valid[i] = 1'b0;
      end
      tb_rsp_ready = ($urandom_range(0, 3) != 0);
      cycle_begin();
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      cycle_end();
    end
    for (int i = 0; i < NREQ; i++) tb_valid[i] = 1'b0;
    tb_rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle_begin();
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL random_drain c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      cycle_end();
    end
    checks++;
    if (obs_rsp_id_q.size() != model_grants) begin
      failures++; $display("FAIL random_rsp_count got=%0d exp=%0d", obs_rsp_id_q.size(), model_grants);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_reset_mid_op();
    test_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fadd_share_arb.md
Name: fadd_share_arb

Overview:
- Time-shares one combinational `fadd` instance (x1, x2 -> y, ovf) among NREQ requesters.
- Requesters use a valid/ready handshake. Arbitration is round-robin.
- Each operation goes through a three-state sequencer: accept, compute, respond.
- Operands and result are registered, so `fadd`'s combinational path is isolated between flops. The block sits between FPU clients (e.g. accumulators, dot-product sequencers) and the single shared adder.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), requester-ID width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operation request.
- req_x1  input  32*NREQ  operand 1, requester i in bits [32i+31:32i].
- req_x2  input  32*NREQ  operand 2, same packing.
- req_ready  output  NREQ  one-hot accept; combinational from state, pointer and req_valid.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_y  output  32  registered `fadd` sum.
- rsp_ovf  output  1  registered `fadd` overflow flag.
- rsp_id  output  IDW  index of the requester that owns the result.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, rr_ptr=0, operand regs=0, rsp_y=0, rsp_ovf=0, rsp_id=0, rsp_valid=0. req_ready=0 while rstn is low.
- Operation issued: an in-flight operation is discarded by reset, with no response. After reset releases, the first grant goes to the lowest valid index at or above 0.
- States: IDLE, CALC, RESP.
- IDLE:
  - If req_valid != 0, grant g = first set bit of req_valid searching from rr_ptr upward, wrapping at NREQ-1 -> 0.
  - req_ready[g]=1 in this cycle only; all other bits are 0.
  - At the edge: capture req_x1[g], req_x2[g] into op regs; rsp_id<=g; rr_ptr <= (g+1) mod NREQ; next state CALC.
  - If req_valid == 0: stay in IDLE, req_ready=0.
- CALC:
  - Op regs drive the `fadd` inputs.
  - At the edge: rsp_y<=y, rsp_ovf<=ovf; next state RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_y, rsp_ovf, rsp_id held stable.
  - If rsp_ready=1 at the edge: next state IDLE, rsp_valid deasserts next cycle.
  - Otherwise stay in RESP indefinitely (backpressure); req_ready=0 throughout.
- Latency: accept edge t -> rsp_valid high from t+2. Peak throughput is 1 op per 3 cycles when rsp_ready is tied high.
- Requester rules:
  - A requester must hold req_valid and its operands stable until its req_ready is seen.
  - Dropping req_valid before grant is legal; that request is then simply not issued.
- rr_ptr changes only on a grant. Requests that arrive while the block is in CALC or RESP wait; they are not lost.
- rsp_y/rsp_ovf are exactly `fadd`'s outputs for the captured operands. No rounding or special-value handling is added in this block.
- NREQ=1 must also elaborate: rr_ptr is constant 0 and IDW=1.

Test Plan:
1. NREQ=4, rsp_ready=1; requester 0 sends x1=0x3F800000, x2=0x3F800000 -> req_ready=4'b0001 for one cycle; two cycles later rsp_valid=1, rsp_y=0x40000000, rsp_ovf=0, rsp_id=0.
2. All four requesters valid continuously, requester i adding 0x3FC00000+0x40100000 -> grant order 0,1,2,3,0,1; each rsp_y=0x40700000; grants exactly 3 cycles apart.
3. Requester 2 sends x1=0xFF2D94EB, x2=0xFF3B0723 -> rsp_y=0xFF800000, rsp_ovf=1, rsp_id=2.
4. Backpressure: rsp_ready=0 for 5 cycles during RESP, with requesters 1 and 3 valid -> rsp_y/rsp_id stable and req_ready=0 throughout. After rsp_ready=1, return to IDLE, then grant to 3 (rr_ptr was 3 after granting 2), then to 1.
5. Reset mid-op: assert rstn=0 asynchronously while in CALC -> rsp_valid=0 immediately and no response for the aborted op. After release with only requester 3 valid -> grant 3, then rr_ptr=0.
6. Requester 1 drops req_valid in the same cycle that requester 0 is granted -> requester 1 is never granted; no spurious response.
